// File: rtl/fp_operand_mux_pipe.sv
// N:1 W-bit operand selector with a registered output and a 2-entry skid buffer.
// Optional macro FP_MUX_SEL_CHECK_EN flags out-of-range selects on out_err.
module fp_operand_mux_pipe #(
  parameter  int W  = 24,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_err
);

  logic [W-1:0] mux_data;
  logic         sel_err;
  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         skid_err;
  logic         accept;

  // Unmatched selects fall through to the zero default, so out-of-range codes give 0.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SW'(k)) mux_data = in_data[k*W +: W];
    end
  end

`ifdef FP_MUX_SEL_CHECK_EN
  always_comb begin
    sel_err = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SW'(k)) sel_err = 1'b0;
    end
  end
`else
  assign sel_err = 1'b0;
`endif

  // in_ready depends only on a register, never on out_ready.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else if (skid_valid) begin
      // Main is necessarily full here; drain skid into it on a pop.
      if (out_ready) begin
        out_data   <= skid_data;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        out_data  <= mux_data;
        out_err   <= sel_err;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= mux_data;
        skid_err   <= sel_err;
        skid_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
`ifdef FP_MUX_SEL_CHECK_EN
`ifndef SYNTHESIS
    if (!reset && accept && sel_err) $display("fp_operand_mux_pipe: bad sel %d", in_sel);
`endif
`endif
  end

endmodule

// File: tb/tb_fp_operand_mux_pipe.sv
// Self-checking bench for fp_operand_mux_pipe: vector table, directed handshake
// sequences, and a randomized run against a queue-based reference model.
module tb_fp_operand_mux_pipe;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*W-1:0] in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_err;

  logic [3*W-1:0] in_data3;
  logic [1:0]    in_sel3;
  logic          in_valid3;
  logic          in_ready3;
  logic [W-1:0]  out_data3;
  logic          out_valid3;
  logic          out_ready3;
  logic          out_err3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_operand_mux_pipe #(.W(W), .N(4)) dut4 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err)
  );

  fp_operand_mux_pipe #(.W(W), .N(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_err(out_err3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4*W-1:0] data;
    logic [1:0]     sel;
    logic [W-1:0]   exp;
  } vec_t;

  localparam logic [4*W-1:0] CH4321 = {24'd4, 24'd3, 24'd2, 24'd1};
  localparam logic [4*W-1:0] CHMIX  = {24'hABCDEF, 24'h123456, 24'hFFFFFF, 24'h000000};

  vec_t vecs[8];
  logic [W-1:0] q[$];
  logic [W-1:0] exp_item;
  logic         acc, pop;
  logic         exp_err3;

  initial begin
    vecs[0] = '{CH4321, 2'd2, 24'd3};
    vecs[1] = '{CH4321, 2'd0, 24'd1};
    vecs[2] = '{CH4321, 2'd1, 24'd2};
    vecs[3] = '{CH4321, 2'd3, 24'd4};
    vecs[4] = '{CHMIX,  2'd0, 24'h000000};
    vecs[5] = '{CHMIX,  2'd1, 24'hFFFFFF};
    vecs[6] = '{CHMIX,  2'd2, 24'h123456};
    vecs[7] = '{CHMIX,  2'd3, 24'hABCDEF};

`ifdef FP_MUX_SEL_CHECK_EN
    exp_err3 = 1'b1;
`else
    exp_err3 = 1'b0;
`endif

    reset = 1'b1; in_data = CH4321; in_sel = '0; in_valid = 1'b1; out_ready = 1'b1;
    in_data3 = {24'd3, 24'd2, 24'd1}; in_sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_err", out_err, 0);
    check("reset in_ready", in_ready, 1);
    check("reset in_ready n3", in_ready3, 1);

    // Single item per vector: one-cycle latency, one-cycle valid pulse.
    for (int i = 0; i < 8; i++) begin
      in_data = vecs[i].data; in_sel = vecs[i].sel; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d pulse end", i), out_valid, 0);
    end

    // Streaming at full rate.
    in_data = CH4321; in_sel = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("stream%0d out_data", i), out_data, i + 1);
      check($sformatf("stream%0d out_valid", i), out_valid, 1);
      check($sformatf("stream%0d in_ready", i), in_ready, 1);
      if (i < 3) in_sel = 2'(i + 1);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    check("stream drained", out_valid, 0);

    // Backpressure fills main then skid; extra offer while full must be ignored.
    out_ready = 1'b0; in_sel = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    check("bp main", out_data, 1);
    check("bp in_ready first", in_ready, 1);
    in_sel = 2'd3;
    @(negedge clk);
    check("bp in_ready low", in_ready, 0);
    in_sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d out_data", i), out_data, 1);
      check($sformatf("hold%0d out_valid", i), out_valid, 1);
      check($sformatf("hold%0d in_ready", i), in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp second out_data", out_data, 4);
    check("bp second out_valid", out_valid, 1);
    check("bp in_ready back", in_ready, 1);
    @(negedge clk);
    check("bp no stale item", out_valid, 0);

    // Reset with both entries full and a simultaneous offer.
    out_ready = 1'b0; in_sel = 2'd1; in_valid = 1'b1;
    @(negedge clk);
    in_sel = 2'd2;
    @(negedge clk);
    check("mid full in_ready", in_ready, 0);
    in_sel = 2'd3; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("mid reset out_valid", out_valid, 0);
    check("mid reset out_data", out_data, 0);
    check("mid reset in_ready", in_ready, 1);
    repeat (2) begin
      @(negedge clk);
      check("post reset no stale", out_valid, 0);
    end

    // N=3 instance: out-of-range select gives zero data.
    in_sel3 = 2'd3; in_valid3 = 1'b1;
    @(negedge clk);
    in_sel3 = 2'd2;
    check("badsel out_valid", out_valid3, 1);
    check("badsel out_data", out_data3, 0);
    check("badsel out_err", out_err3, exp_err3);
    @(negedge clk);
    in_valid3 = 1'b0;
    check("n3 sel2 out_data", out_data3, 3);
    check("n3 sel2 out_err", out_err3, 0);
    @(negedge clk);
    check("n3 drained", out_valid3, 0);

    // Randomized traffic against a FIFO model holding at most two items.
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      check("rnd in_ready", in_ready, q.size() < 2);
      check("rnd out_valid", out_valid, q.size() != 0);
      check("rnd out_err", out_err, 0);
      if (q.size() != 0) check("rnd out_data", out_data, q[0]);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = {$urandom(), $urandom(), $urandom()};
      exp_item  = W'((in_data >> (int'(in_sel) * W)) & 96'hFFFFFF);
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(exp_item);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
